// File: rtl/mmio_wr_fifo.sv
// rtl/mmio_wr_fifo.sv - circular-buffer write FIFO between MMIO write decode and read-response mux
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   wr_en, wr_data         push one word
//   rd_en                  pop head; rd_data/rd_valid follow one cycle later
//   rd_data, rd_valid      registered pop result and its one-cycle qualifier
//   peek_data              combinational head entry (undefined while empty)
//   flush                  synchronous clear of contents (wins over push/pop)
//   clr_err                clears sticky overflow/underflow
//   full, empty, count     occupancy status from the registered count
//   overflow, underflow    sticky error flags
module mmio_wr_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     rd_valid,
    output logic [WIDTH-1:0]         peek_data,
    input  logic                     flush,
    input  logic                     clr_err,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    generate
        if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
            $error("mmio_wr_fifo: DEPTH must be a power of two and at least 2");
        end
    endgenerate

    logic [WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;

    logic             full_s, empty_s;
    logic             push_ok, pop_ok;
    logic             ovf_evt, udf_evt;

    assign full_s  = (count_q == CW'(DEPTH));
    assign empty_s = (count_q == '0);

    // Flush masks both requests, so it never raises an error flag either.
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts
    // a push that coincides with a pop; there is no bypass in the empty case.
    assign pop_ok  = rd_en & ~flush & ~empty_s;
    assign push_ok = wr_en & ~flush & (~full_s | pop_ok);
    assign ovf_evt = wr_en & ~flush & ~push_ok;
    assign udf_evt = rd_en & ~flush & ~pop_ok;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        rd_data_d   = rd_data_q;
        rd_valid_d  = 1'b0;
        // A new error wins over a coincident clear.
        overflow_d  = ovf_evt | (overflow_q & ~clr_err);
        underflow_d = udf_evt | (underflow_q & ~clr_err);

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_ok) begin
                rd_data_d  = mem[rd_ptr_q];
                rd_valid_d = 1'b1;
                rd_ptr_d   = rd_ptr_q + AW'(1);
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            rd_data_q   <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            rd_data_q   <= rd_data_d;
            rd_valid_q  <= rd_valid_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= wr_data;
        end
    end

    assign rd_data   = rd_data_q;
    assign rd_valid  = rd_valid_q;
    assign peek_data = mem[rd_ptr_q];
    assign full      = full_s;
    assign empty     = empty_s;
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule
